mod_datapath: RTL

MOD_DATAPATH -- requirements
Module: mod_datapath

---
 rtl/mod_pkg.sv | 29 ++
 rtl/mod_sub_cmp.sv | 18 +
 rtl/mod_datapath.sv | 88 ++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared defaults and encodings for the modulo datapath.
package mod_pkg;

   // Default operand/result width and subtract-iteration counter width.
   localparam int W_DEF      = 8;
   localparam int ITER_W_DEF = 16;

   // Load source select driven by the controller on the mux input.
   localparam logic MUX_OPERAND = 1'b0;
   localparam logic MUX_SUB     = 1'b1;

   // Decoded register-load action for one cycle.
   typedef enum logic [1:0] {
      LD_NONE    = 2'd0,
      LD_OPERAND = 2'd1,
      LD_SUB     = 2'd2
   } ld_op_e;

   // Turn the raw ld/mux strobes into a single load action.
   function automatic ld_op_e decode_ld(input logic ld, input logic mux);
      if (!ld)
         return LD_NONE;
      else if (mux == MUX_OPERAND)
         return LD_OPERAND;
      else
         return LD_SUB;
   endfunction

endpackage

// File: rtl/mod_sub_cmp.sv
// Combinational subtractor and divisor compare for the modulo datapath.
module mod_sub_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         b_less
);

   // Wrapping difference, plus "another subtraction is needed"; a zero
   // divisor never asks for a subtraction so the controller terminates.
   always_comb begin
      diff   = a - b;
      b_less = (b != '0) && (b <= a);
   end

endmodule

// File: rtl/mod_datapath.sv
// Repeated-subtraction a mod b datapath, steered by an external controller.
module mod_datapath
   import mod_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int ITER_W = ITER_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      a_in,
   input  logic [W-1:0]      b_in,
   input  logic              ld,
   input  logic              mux,
   input  logic              mod_fin,
   output logic              b_less,
   output logic [W-1:0]      result,
   output logic              result_valid,
   output logic              div_zero,
   output logic [ITER_W-1:0] iter_cnt
);

   localparam logic [ITER_W-1:0] ITER_MAX = '1;

   logic [W-1:0] reg_a;
   logic [W-1:0] reg_b;
   logic [W-1:0] diff;
   ld_op_e       ld_op;

   assign ld_op = decode_ld(ld, mux);

   mod_sub_cmp #(.W(W)) u_sub_cmp (
      .a      (reg_a),
      .b      (reg_b),
      .diff   (diff),
      .b_less (b_less)
   );

   // Working remainder/divisor: load operands or step the remainder down.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_a <= '0;
         reg_b <= '0;
      end else begin
         case (ld_op)
            LD_OPERAND: begin
               reg_a <= a_in;
               reg_b <= b_in;
            end
            LD_SUB:  reg_a <= diff;
            default: ;
         endcase
      end
   end

   // Subtract-step counter; clears on operand load, saturates at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         iter_cnt <= '0;
      else if (ld_op == LD_OPERAND)
         iter_cnt <= '0;
      else if (ld_op == LD_SUB && iter_cnt != ITER_MAX)
         iter_cnt <= iter_cnt + 1'b1;
   end

   // Result capture on finish; takes the pre-edge remainder even when a
   // load lands in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         result <= '0;
      else if (mod_fin)
         result <= reg_a;
   end

   // Completion status; a new operand load beats a coincident finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_valid <= 1'b0;
         div_zero     <= 1'b0;
      end else if (ld_op == LD_OPERAND) begin
         result_valid <= 1'b0;
         div_zero     <= 1'b0;
      end else if (mod_fin) begin
         result_valid <= 1'b1;
         div_zero     <= (reg_b == '0);
      end
   end

endmodule
